cpu: RTL and testbench
======================

// Module: cpu
// PURPOSE
//  Hardwired microcontroller for the TEC-8 style teaching CPU. Decodes console mode
//  switches {swc,swb,swa}, beat pulses w1..w3, opcode ir[7:4] and flags c/z into
//  combinational datapath control strobes. One internal state bit ST0 separates
//  the first-pass (address/PC load, R0/R1 write) from the second pass.
// PARAMETERS
//  none
// PORTS
//  t3     in  1  clock; ST0 updates on rising edge
//  clr    in  1  reset, synchronous, active-high; clears ST0 on t3 edge
//  swc,swb,swa in 1 each  console mode {swc,swb,swa}
//  ir     in  4  opcode ir[7:4]
//  w1,w2,w3 in 1 each  one-hot beat pulses from timing unit
//  c,z    in  1  carry / zero flags
//  s      out 4  ALU function select; m out 1 ALU logic mode; cin out 1 carry-in
//  drw,pcinc,lpc,lar,pcadd,arinc,selctl,memw,stop,lir,ldz,ldc  out 1 each  strobes
//  abus,sbus,mbus out 1  bus drivers (ALU / switches / memory)
//  short,long out 1  end after W1 / extend to W3
//  sel3,sel2 out 1  dest reg index; sel1,sel0 out 1  source reg index
// BEHAVIOUR
//  - All outputs combinational; any signal not listed for a case is 0.
//  - clr=1: every output 0; at next t3 edge ST0<=0. ST0 reset value 0.
//  - selctl=1 in all console modes (mode!=000) and 0 in mode 000.
//  - 100 write reg: w1,w2: sbus,drw,stop; {sel3,sel2}={ST0,w2}; sel1,sel0 copy
//    sel3,sel2. At w2 with ST0=0, ST0<=1 (R0,R1 then R2,R3).
//  - 011 read reg: w1: sel=0001 (R0/R1); w2: sel=1011 (R2/R3); stop in both.
//  - 010 read mem: ST0=0,w1: sbus,lar,stop,short, ST0<=1. ST0=1,w1: mbus,arinc,stop,short.
//  - 001 write mem: ST0=0,w1: sbus,lar,stop,short, ST0<=1. ST0=1,w1: sbus,memw,arinc,stop,short.
//  - 000 run: ST0=0,w1: sbus,lpc,stop,short, ST0<=1. ST0=1,w1: lir,pcinc (fetch).
//    ST0=1,w2/w3 by ir:
//    0000 NOP: none.  0001 ADD w2: s=1001,cin,abus,drw,ldz,ldc.
//    0010 SUB w2: s=0110,abus,drw,ldz,ldc.  0011 AND w2: m,s=1011,abus,drw,ldz.
//    0100 INC w2: s=0000,abus,drw,ldz,ldc.
//    0101 LD  w2: m,s=1010,abus,lar,long; w3: mbus,drw.
//    0110 ST  w2: m,s=1111,abus,lar,long; w3: m,s=1010,abus,memw.
//    0111 JC  w2: pcadd=c.  1000 JZ w2: pcadd=z.  1001 JMP w2: m,s=1111,abus,lpc.
//    1110 STP w2: stop.  other opcodes: NOP.
//  - ST0 only set as above, only cleared by clr; changing mode does not clear it.
//  - No beat asserted: all outputs 0 except selctl per mode.
// TESTING
//  clr=1 one t3 edge, mode 000, w1=1 -> sbus,lpc,stop,short=1; lir=0; ST0 then 1 after edge w/ clr=0.
//  ST0=1, mode 000, w1 -> lir=pcinc=1; w2 ir=0001 -> s=1001,cin,abus,drw,ldz,ldc=1.
//  ST0=1, ir=0101: w2 -> lar,long,m,s=1010; w3 -> mbus,drw=1, lar=0.
//  ST0=1, ir=0111, w2: c=0 -> pcadd=0; c=1 -> pcadd=1; ir=1000 z=1 -> pcadd=1.
//  mode 100 after clr: w1 sel=0000, w2 sel=0101, edge, w1 sel=1010, w2 sel=1111; drw=1.
//  mode 001: first w1 lar=1,memw=0; after edge w1 memw=arinc=1,lar=0.

Source files
------------

// File: rtl/cpu.sv
// rtl/cpu.sv - hardwired TEC-8 style microcontroller
// Decodes console mode, beat pulses, opcode and flags into datapath control strobes.
module cpu (
    input  logic       t3,
    input  logic       clr,
    input  logic       swc,
    input  logic       swb,
    input  logic       swa,
    input  logic [3:0] ir,
    input  logic       w1,
    input  logic       w2,
    input  logic       w3,
    input  logic       c,
    input  logic       z,
    output logic [3:0] s,
    output logic       m,
    output logic       cin,
    output logic       drw,
    output logic       pcinc,
    output logic       lpc,
    output logic       lar,
    output logic       pcadd,
    output logic       arinc,
    output logic       selctl,
    output logic       memw,
    output logic       stop,
    output logic       lir,
    output logic       ldz,
    output logic       ldc,
    output logic       abus,
    output logic       sbus,
    output logic       mbus,
    output logic       short_cycle,
    output logic       long_cycle,
    output logic       sel3,
    output logic       sel2,
    output logic       sel1,
    output logic       sel0
);

    typedef enum logic {
        PASS1 = 1'b0,
        PASS2 = 1'b1
    } pass_t;

    localparam logic [2:0] MODE_RUN     = 3'b000;
    localparam logic [2:0] MODE_WR_MEM  = 3'b001;
    localparam logic [2:0] MODE_RD_MEM  = 3'b010;
    localparam logic [2:0] MODE_RD_REG  = 3'b011;
    localparam logic [2:0] MODE_WR_REG  = 3'b100;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_INC = 4'b0100;
    localparam logic [3:0] OP_LD  = 4'b0101;
    localparam logic [3:0] OP_ST  = 4'b0110;
    localparam logic [3:0] OP_JC  = 4'b0111;
    localparam logic [3:0] OP_JZ  = 4'b1000;
    localparam logic [3:0] OP_JMP = 4'b1001;
    localparam logic [3:0] OP_STP = 4'b1110;

    pass_t      state;
    pass_t      next_state;
    logic [2:0] mode;
    logic       st0;

    assign mode = {swc, swb, swa};
    assign st0  = (state == PASS2);

    // ST0 is never cleared by a mode change; only clr returns it to the first pass.
    always_ff @(posedge t3) begin
        if (clr) begin
            state <= PASS1;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        s           = 4'b0000;
        m           = 1'b0;
        cin         = 1'b0;
        drw         = 1'b0;
        pcinc       = 1'b0;
        lpc         = 1'b0;
        lar         = 1'b0;
        pcadd       = 1'b0;
        arinc       = 1'b0;
        selctl      = 1'b0;
        memw        = 1'b0;
        stop        = 1'b0;
        lir         = 1'b0;
        ldz         = 1'b0;
        ldc         = 1'b0;
        abus        = 1'b0;
        sbus        = 1'b0;
        mbus        = 1'b0;
        short_cycle = 1'b0;
        long_cycle  = 1'b0;
        sel3        = 1'b0;
        sel2        = 1'b0;
        sel1        = 1'b0;
        sel0        = 1'b0;

        if (!clr) begin
            selctl = (mode != MODE_RUN);
            case (mode)
                MODE_WR_REG: begin
                    // First pass writes R0/R1, second pass R2/R3; source index mirrors dest.
                    if (w1 || w2) begin
                        sbus = 1'b1;
                        drw  = 1'b1;
                        stop = 1'b1;
                        sel3 = st0;
                        sel2 = w2;
                        sel1 = st0;
                        sel0 = w2;
                        if (w2 && !st0) next_state = PASS2;
                    end
                end
                MODE_RD_REG: begin
                    if (w1) begin
                        stop = 1'b1;
                        sel0 = 1'b1;
                    end else if (w2) begin
                        stop = 1'b1;
                        sel3 = 1'b1;
                        sel1 = 1'b1;
                        sel0 = 1'b1;
                    end
                end
                MODE_RD_MEM: begin
                    if (w1) begin
                        stop        = 1'b1;
                        short_cycle = 1'b1;
                        if (!st0) begin
                            sbus       = 1'b1;
                            lar        = 1'b1;
                            next_state = PASS2;
                        end else begin
                            mbus  = 1'b1;
                            arinc = 1'b1;
                        end
                    end
                end
                MODE_WR_MEM: begin
                    if (w1) begin
                        sbus        = 1'b1;
                        stop        = 1'b1;
                        short_cycle = 1'b1;
                        if (!st0) begin
                            lar        = 1'b1;
                            next_state = PASS2;
                        end else begin
                            memw  = 1'b1;
                            arinc = 1'b1;
                        end
                    end
                end
                MODE_RUN: begin
                    if (!st0) begin
                        if (w1) begin
                            sbus        = 1'b1;
                            lpc         = 1'b1;
                            stop        = 1'b1;
                            short_cycle = 1'b1;
                            next_state  = PASS2;
                        end
                    end else if (w1) begin
                        lir   = 1'b1;
                        pcinc = 1'b1;
                    end else if (w2) begin
                        case (ir)
                            OP_ADD: begin
                                s    = 4'b1001;
                                cin  = 1'b1;
                                abus = 1'b1;
                                drw  = 1'b1;
                                ldz  = 1'b1;
                                ldc  = 1'b1;
                            end
                            OP_SUB: begin
                                s    = 4'b0110;
                                abus = 1'b1;
                                drw  = 1'b1;
                                ldz  = 1'b1;
                                ldc  = 1'b1;
                            end
                            OP_AND: begin
                                m    = 1'b1;
                                s    = 4'b1011;
                                abus = 1'b1;
                                drw  = 1'b1;
                                ldz  = 1'b1;
                            end
                            OP_INC: begin
                                s    = 4'b0000;
                                abus = 1'b1;
                                drw  = 1'b1;
                                ldz  = 1'b1;
                                ldc  = 1'b1;
                            end
                            OP_LD: begin
                                m          = 1'b1;
                                s          = 4'b1010;
                                abus       = 1'b1;
                                lar        = 1'b1;
                                long_cycle = 1'b1;
                            end
                            OP_ST: begin
                                m          = 1'b1;
                                s          = 4'b1111;
                                abus       = 1'b1;
                                lar        = 1'b1;
                                long_cycle = 1'b1;
                            end
                            OP_JC:  pcadd = c;
                            OP_JZ:  pcadd = z;
                            OP_JMP: begin
                                m    = 1'b1;
                                s    = 4'b1111;
                                abus = 1'b1;
                                lpc  = 1'b1;
                            end
                            OP_STP: stop = 1'b1;
                            OP_NOP: ;
                            default: ;
                        endcase
                    end else if (w3) begin
                        // Only the memory-access instructions extend into W3.
                        if (ir == OP_LD) begin
                            mbus = 1'b1;
                            drw  = 1'b1;
                        end else if (ir == OP_ST) begin
                            m    = 1'b1;
                            s    = 4'b1010;
                            abus = 1'b1;
                            memw = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu.sv
// tb/tb_cpu.sv - directed self-checking bench for cpu
module tb_cpu;

    logic       t3 = 1'b0;
    logic       clr;
    logic       swc, swb, swa;
    logic [3:0] ir;
    logic       w1, w2, w3;
    logic       c, z;
    logic [3:0] s;
    logic       m, cin, drw, pcinc, lpc, lar, pcadd, arinc, selctl, memw, stop;
    logic       lir, ldz, ldc, abus, sbus, mbus, short_cycle, long_cycle;
    logic       sel3, sel2, sel1, sel0;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [26:0] M_M     = 27'h1 << 22;
    localparam logic [26:0] M_CIN   = 27'h1 << 21;
    localparam logic [26:0] M_DRW   = 27'h1 << 20;
    localparam logic [26:0] M_PCINC = 27'h1 << 19;
    localparam logic [26:0] M_LPC   = 27'h1 << 18;
    localparam logic [26:0] M_LAR   = 27'h1 << 17;
    localparam logic [26:0] M_PCADD = 27'h1 << 16;
    localparam logic [26:0] M_ARINC = 27'h1 << 15;
    localparam logic [26:0] M_SELC  = 27'h1 << 14;
    localparam logic [26:0] M_MEMW  = 27'h1 << 13;
    localparam logic [26:0] M_STOP  = 27'h1 << 12;
    localparam logic [26:0] M_LIR   = 27'h1 << 11;
    localparam logic [26:0] M_LDZ   = 27'h1 << 10;
    localparam logic [26:0] M_LDC   = 27'h1 << 9;
    localparam logic [26:0] M_ABUS  = 27'h1 << 8;
    localparam logic [26:0] M_SBUS  = 27'h1 << 7;
    localparam logic [26:0] M_MBUS  = 27'h1 << 6;
    localparam logic [26:0] M_SHORT = 27'h1 << 5;
    localparam logic [26:0] M_LONG  = 27'h1 << 4;

    logic [26:0] obs;
    assign obs = {s, m, cin, drw, pcinc, lpc, lar, pcadd, arinc, selctl, memw, stop,
                  lir, ldz, ldc, abus, sbus, mbus, short_cycle, long_cycle,
                  sel3, sel2, sel1, sel0};

    cpu dut (
        .t3(t3), .clr(clr), .swc(swc), .swb(swb), .swa(swa), .ir(ir),
        .w1(w1), .w2(w2), .w3(w3), .c(c), .z(z),
        .s(s), .m(m), .cin(cin), .drw(drw), .pcinc(pcinc), .lpc(lpc), .lar(lar),
        .pcadd(pcadd), .arinc(arinc), .selctl(selctl), .memw(memw), .stop(stop),
        .lir(lir), .ldz(ldz), .ldc(ldc), .abus(abus), .sbus(sbus), .mbus(mbus),
        .short_cycle(short_cycle), .long_cycle(long_cycle),
        .sel3(sel3), .sel2(sel2), .sel1(sel1), .sel0(sel0)
    );

    always #5 t3 = ~t3;

    function automatic logic [26:0] sf(input logic [3:0] v);
        return {v, 23'b0};
    endfunction

    function automatic logic [26:0] sl(input logic [3:0] v);
        return {23'b0, v};
    endfunction

    task automatic drive(input logic [2:0] md, input logic [2:0] w, input logic [3:0] op);
        {swc, swb, swa} = md;
        {w1, w2, w3}    = w;
        ir              = op;
        #1;
    endtask

    task automatic edge_t3();
        @(posedge t3);
        #1;
    endtask

    task automatic chk(input string tag, input logic [26:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %07h expected %07h", tag, obs, exp);
        end
    endtask

    initial begin
        clr = 1'b1; c = 1'b0; z = 1'b0;
        drive(3'b000, 3'b100, 4'b0000);
        chk("clr_all_zero", 27'h0);
        edge_t3();
        clr = 1'b0;
        drive(3'b000, 3'b100, 4'b0000);
        chk("run_st0_w1", M_SBUS | M_LPC | M_STOP | M_SHORT);
        edge_t3();
        drive(3'b000, 3'b100, 4'b0000);
        chk("fetch_w1", M_LIR | M_PCINC);
        drive(3'b000, 3'b010, 4'b0001);
        chk("add_w2", sf(4'b1001) | M_CIN | M_ABUS | M_DRW | M_LDZ | M_LDC);
        drive(3'b000, 3'b010, 4'b0010);
        chk("sub_w2", sf(4'b0110) | M_ABUS | M_DRW | M_LDZ | M_LDC);
        drive(3'b000, 3'b010, 4'b0011);
        chk("and_w2", M_M | sf(4'b1011) | M_ABUS | M_DRW | M_LDZ);
        drive(3'b000, 3'b010, 4'b0100);
        chk("inc_w2", M_ABUS | M_DRW | M_LDZ | M_LDC);
        drive(3'b000, 3'b010, 4'b0101);
        chk("ld_w2", M_M | sf(4'b1010) | M_ABUS | M_LAR | M_LONG);
        drive(3'b000, 3'b001, 4'b0101);
        chk("ld_w3", M_MBUS | M_DRW);
        drive(3'b000, 3'b010, 4'b0110);
        chk("st_w2", M_M | sf(4'b1111) | M_ABUS | M_LAR | M_LONG);
        drive(3'b000, 3'b001, 4'b0110);
        chk("st_w3", M_M | sf(4'b1010) | M_ABUS | M_MEMW);
        drive(3'b000, 3'b001, 4'b0001);
        chk("add_w3_none", 27'h0);
        c = 1'b0;
        drive(3'b000, 3'b010, 4'b0111);
        chk("jc_c0", 27'h0);
        c = 1'b1;
        drive(3'b000, 3'b010, 4'b0111);
        chk("jc_c1", M_PCADD);
        z = 1'b1; c = 1'b0;
        drive(3'b000, 3'b010, 4'b1000);
        chk("jz_z1", M_PCADD);
        z = 1'b0; c = 1'b1;
        drive(3'b000, 3'b010, 4'b1000);
        chk("jz_z0", 27'h0);
        c = 1'b0;
        drive(3'b000, 3'b010, 4'b1001);
        chk("jmp_w2", M_M | sf(4'b1111) | M_ABUS | M_LPC);
        drive(3'b000, 3'b010, 4'b1110);
        chk("stp_w2", M_STOP);
        drive(3'b000, 3'b010, 4'b1111);
        chk("op1111_nop", 27'h0);
        drive(3'b000, 3'b000, 4'b0001);
        chk("run_no_beat", 27'h0);

        // mode 100 from a cleared ST0
        clr = 1'b1;
        drive(3'b100, 3'b100, 4'b0000);
        chk("clr_mode100", 27'h0);
        edge_t3();
        clr = 1'b0;
        drive(3'b100, 3'b100, 4'b0000);
        chk("wreg_r0", M_SELC | M_SBUS | M_DRW | M_STOP | sl(4'b0000));
        drive(3'b100, 3'b010, 4'b0000);
        chk("wreg_r1", M_SELC | M_SBUS | M_DRW | M_STOP | sl(4'b0101));
        edge_t3();
        drive(3'b100, 3'b100, 4'b0000);
        chk("wreg_r2", M_SELC | M_SBUS | M_DRW | M_STOP | sl(4'b1010));
        drive(3'b100, 3'b010, 4'b0000);
        chk("wreg_r3", M_SELC | M_SBUS | M_DRW | M_STOP | sl(4'b1111));
        edge_t3();
        drive(3'b100, 3'b010, 4'b0000);
        chk("wreg_st0_held", M_SELC | M_SBUS | M_DRW | M_STOP | sl(4'b1111));
        drive(3'b100, 3'b001, 4'b0000);
        chk("wreg_w3", M_SELC);

        drive(3'b011, 3'b100, 4'b0000);
        chk("rreg_w1", M_SELC | M_STOP | sl(4'b0001));
        drive(3'b011, 3'b010, 4'b0000);
        chk("rreg_w2", M_SELC | M_STOP | sl(4'b1011));
        drive(3'b011, 3'b000, 4'b0000);
        chk("rreg_no_beat", M_SELC);

        // ST0 still 1 after the mode change
        drive(3'b001, 3'b100, 4'b0000);
        chk("wmem_st0_kept", M_SELC | M_SBUS | M_MEMW | M_ARINC | M_STOP | M_SHORT);
        drive(3'b010, 3'b100, 4'b0000);
        chk("rmem_st1", M_SELC | M_MBUS | M_ARINC | M_STOP | M_SHORT);

        clr = 1'b1;
        edge_t3();
        clr = 1'b0;
        drive(3'b001, 3'b100, 4'b0000);
        chk("wmem_first", M_SELC | M_SBUS | M_LAR | M_STOP | M_SHORT);
        edge_t3();
        drive(3'b001, 3'b100, 4'b0000);
        chk("wmem_second", M_SELC | M_SBUS | M_MEMW | M_ARINC | M_STOP | M_SHORT);

        clr = 1'b1;
        edge_t3();
        clr = 1'b0;
        drive(3'b010, 3'b100, 4'b0000);
        chk("rmem_first", M_SELC | M_SBUS | M_LAR | M_STOP | M_SHORT);
        drive(3'b111, 3'b100, 4'b0000);
        chk("mode111_w1", M_SELC);
        edge_t3();
        drive(3'b000, 3'b100, 4'b0000);
        chk("mode111_no_set", M_SBUS | M_LPC | M_STOP | M_SHORT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
